uart_tx_cfg: RTL and testbench



---
 rtl/uart_tx_cfg.sv | 235 +++++++++++++++++++++++
 tb/tb_uart_tx_cfg.sv | 316 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_cfg.sv
// uart_tx_cfg: configurable UART transmitter (5..9 data bits, none/odd/even parity, 1 or 2 stop bits).
// Latency: tx drives the start bit from the accept edge E0; each frame occupies F*CPB cycles, then one IDLE cycle.
// Backpressure: s_ready is high only in IDLE (and not in reset); a held s_valid is taken on the first IDLE cycle.
//
// Ports:
//    clk        system clock
//    reset      synchronous, active-high reset (aborts any frame in flight, no done pulse)
//    s_data     frame payload, latched on the accept edge
//    s_valid    payload valid
//    s_ready    block can accept a payload this cycle (combinational)
//    tx         UART line, idle high, registered
//    busy       frame or break in progress, registered
//    done       one-cycle pulse after a data frame returns to IDLE
//    send_break line-break request (only with UART_TX_BREAK_EN defined)
//
// Optional feature macro: UART_TX_BREAK_EN adds the send_break port and a BRK state that holds
// tx low for BREAK_BITS bit times followed by the stop bit(s).

module uart_tx_cfg #(
   parameter int CLK_FREQ   = 50_000_000,
   parameter int BAUD_RATE  = 115200,
   parameter int DATA_BITS  = 8,
   parameter int PARITY     = 0,
   parameter int STOP_BITS  = 1,
   parameter int BREAK_BITS = 13
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic [DATA_BITS-1:0] s_data,
   input  logic                 s_valid,
   output logic                 s_ready,
   output logic                 tx,
   output logic                 busy,
   output logic                 done
`ifdef UART_TX_BREAK_EN
   ,
   input  logic                 send_break
`endif
);

   localparam int CPB = CLK_FREQ / BAUD_RATE;
   localparam int CW  = (CPB > 1) ? $clog2(CPB) : 1;
   localparam int IW  = $clog2(DATA_BITS);
   localparam logic [CW-1:0] CPB_LAST = CW'(CPB - 1);
   localparam logic [IW-1:0] IDX_LAST = IW'(DATA_BITS - 1);

   generate
      if (CPB < 2) begin : g_chk_cpb
         $error("uart_tx_cfg: CLK_FREQ/BAUD_RATE must be at least 2");
      end
      if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_chk_data
         $error("uart_tx_cfg: DATA_BITS must be 5..9");
      end
      if (PARITY < 0 || PARITY > 2) begin : g_chk_par
         $error("uart_tx_cfg: PARITY must be 0, 1 or 2");
      end
      if (STOP_BITS != 1 && STOP_BITS != 2) begin : g_chk_stop
         $error("uart_tx_cfg: STOP_BITS must be 1 or 2");
      end
      if (BREAK_BITS < 1) begin : g_chk_brk
         $error("uart_tx_cfg: BREAK_BITS must be at least 1");
      end
   endgenerate

   typedef enum logic [2:0] {
      IDLE,
      START,
      DATA,
      PAR,
      STOP
`ifdef UART_TX_BREAK_EN
      ,
      BRK
`endif
   } state_t;

   state_t               state, state_nxt;
   logic [CW-1:0]        bit_cnt, bit_cnt_nxt;
   logic [IW-1:0]        bit_idx, bit_idx_nxt;
   logic [DATA_BITS-1:0] shreg, shreg_nxt;
   logic                 par_bit, par_bit_nxt;
   logic                 stop_cnt, stop_cnt_nxt;
   logic                 from_brk, from_brk_nxt;
   logic                 tx_nxt;
   logic                 done_nxt;
   logic                 bit_end;

`ifdef UART_TX_BREAK_EN
   localparam int BW = (BREAK_BITS > 1) ? $clog2(BREAK_BITS) : 1;
   localparam logic [BW-1:0] BRK_LAST = BW'(BREAK_BITS - 1);
   logic [BW-1:0] brk_cnt, brk_cnt_nxt;

   // A pending break request takes the line, so the payload is not offered ready.
   assign s_ready = (state == IDLE) && !reset && !send_break;
`else
   assign s_ready = (state == IDLE) && !reset;
`endif

   assign bit_end = (bit_cnt == CPB_LAST);

   // Next-state and next-output logic; tx/busy/done are registered from these so the
   // line level changes on the same edge as the state.
   always_comb begin
      state_nxt    = state;
      bit_cnt_nxt  = bit_end ? '0 : bit_cnt + 1'b1;
      bit_idx_nxt  = bit_idx;
      shreg_nxt    = shreg;
      par_bit_nxt  = par_bit;
      stop_cnt_nxt = stop_cnt;
      from_brk_nxt = from_brk;
      tx_nxt       = tx;
      done_nxt     = 1'b0;
`ifdef UART_TX_BREAK_EN
      brk_cnt_nxt  = brk_cnt;
`endif
      case (state)
         IDLE: begin
            bit_cnt_nxt = '0;
            tx_nxt      = 1'b1;
`ifdef UART_TX_BREAK_EN
            if (send_break) begin
               state_nxt    = BRK;
               tx_nxt       = 1'b0;
               brk_cnt_nxt  = '0;
               from_brk_nxt = 1'b1;
            end else
`endif
            if (s_valid && s_ready) begin
               state_nxt    = START;
               tx_nxt       = 1'b0;
               shreg_nxt    = s_data;
               // Even parity is the plain XOR; odd parity inverts it.
               par_bit_nxt  = (^s_data) ^ (PARITY == 1);
               bit_idx_nxt  = '0;
               stop_cnt_nxt = 1'b0;
               from_brk_nxt = 1'b0;
            end
         end
         START: begin
            if (bit_end) begin
               state_nxt = DATA;
               tx_nxt    = shreg[0];
            end
         end
         DATA: begin
            if (bit_end) begin
               if (bit_idx == IDX_LAST) begin
                  stop_cnt_nxt = 1'b0;
                  if (PARITY != 0) begin
                     state_nxt = PAR;
                     tx_nxt    = par_bit;
                  end else begin
                     state_nxt = STOP;
                     tx_nxt    = 1'b1;
                  end
               end else begin
                  // shreg[0] is always the bit on the line; look one ahead for the next one.
                  bit_idx_nxt = bit_idx + 1'b1;
                  shreg_nxt   = shreg >> 1;
                  tx_nxt      = shreg[1];
               end
            end
         end
         PAR: begin
            if (bit_end) begin
               state_nxt    = STOP;
               tx_nxt       = 1'b1;
               stop_cnt_nxt = 1'b0;
            end
         end
         STOP: begin
            tx_nxt = 1'b1;
            if (bit_end) begin
               if (STOP_BITS == 2 && !stop_cnt) begin
                  stop_cnt_nxt = 1'b1;
               end else begin
                  state_nxt = IDLE;
                  done_nxt  = !from_brk;
               end
            end
         end
`ifdef UART_TX_BREAK_EN
         BRK: begin
            tx_nxt = 1'b0;
            if (bit_end) begin
               if (brk_cnt == BRK_LAST) begin
                  state_nxt    = STOP;
                  tx_nxt       = 1'b1;
                  stop_cnt_nxt = 1'b0;
               end else begin
                  brk_cnt_nxt = brk_cnt + 1'b1;
               end
            end
         end
`endif
         default: begin
            state_nxt = IDLE;
            tx_nxt    = 1'b1;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state    <= IDLE;
         tx       <= 1'b1;
         busy     <= 1'b0;
         done     <= 1'b0;
         bit_cnt  <= '0;
         bit_idx  <= '0;
         shreg    <= '0;
         par_bit  <= 1'b0;
         stop_cnt <= 1'b0;
         from_brk <= 1'b0;
`ifdef UART_TX_BREAK_EN
         brk_cnt  <= '0;
`endif
      end else begin
         state    <= state_nxt;
         tx       <= tx_nxt;
         busy     <= (state_nxt != IDLE);
         done     <= done_nxt;
         bit_cnt  <= bit_cnt_nxt;
         bit_idx  <= bit_idx_nxt;
         shreg    <= shreg_nxt;
         par_bit  <= par_bit_nxt;
         stop_cnt <= stop_cnt_nxt;
         from_brk <= from_brk_nxt;
`ifdef UART_TX_BREAK_EN
         brk_cnt  <= brk_cnt_nxt;
`endif
      end
   end

endmodule

// File: tb/tb_uart_tx_cfg.sv
// Directed bench for uart_tx_cfg at CPB=10 (1 MHz clock, 100 kbit/s).
// Three instances: 8N1, 7E2 and 8O1. Observations are packed as {tx, busy, s_ready, done}
// and sampled on the falling clock edge; cycle k means the cycle after edge E0+k.

module tb_uart_tx_cfg;

   logic clk;
   logic reset;

   logic [7:0] d0;  logic v0; logic r0; logic tx0; logic b0; logic dn0;
   logic [6:0] d1;  logic v1; logic r1; logic tx1; logic b1; logic dn1;
   logic [7:0] d2;  logic v2; logic r2; logic tx2; logic b2; logic dn2;
`ifdef UART_TX_BREAK_EN
   logic sb0;
   logic sb_off;
`endif

   int vectors;
   int miscompares;
   logic [3:0] cap [0:255];
   bit hs_ok;

   uart_tx_cfg #(.CLK_FREQ(1_000_000), .BAUD_RATE(100_000), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1))
   u_8n1 (.clk(clk), .reset(reset), .s_data(d0), .s_valid(v0), .s_ready(r0), .tx(tx0), .busy(b0), .done(dn0)
`ifdef UART_TX_BREAK_EN
      , .send_break(sb0)
`endif
   );

   uart_tx_cfg #(.CLK_FREQ(1_000_000), .BAUD_RATE(100_000), .DATA_BITS(7), .PARITY(2), .STOP_BITS(2))
   u_7e2 (.clk(clk), .reset(reset), .s_data(d1), .s_valid(v1), .s_ready(r1), .tx(tx1), .busy(b1), .done(dn1)
`ifdef UART_TX_BREAK_EN
      , .send_break(sb_off)
`endif
   );

   uart_tx_cfg #(.CLK_FREQ(1_000_000), .BAUD_RATE(100_000), .DATA_BITS(8), .PARITY(1), .STOP_BITS(1))
   u_8o1 (.clk(clk), .reset(reset), .s_data(d2), .s_valid(v2), .s_ready(r2), .tx(tx2), .busy(b2), .done(dn2)
`ifdef UART_TX_BREAK_EN
      , .send_break(sb_off)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [3:0] get_obs(input int inst);
      case (inst)
         0:       return {tx0, b0, r0, dn0};
         1:       return {tx1, b1, r1, dn1};
         default: return {tx2, b2, r2, dn2};
      endcase
   endfunction

   task automatic set_in(input int inst, input logic [8:0] d, input logic v);
      case (inst)
         0:       begin d0 = d[7:0]; v0 = v; end
         1:       begin d1 = d[6:0]; v1 = v; end
         default: begin d2 = d[7:0]; v2 = v; end
      endcase
   endtask

   // Offers one payload, waits (bounded) for acceptance, then records ncyc cycles from cycle 0.
   task automatic capture(input int inst, input logic [8:0] d, input int ncyc);
      logic [3:0] obs;
      int n;
      hs_ok = 1'b0;
      @(negedge clk);
      set_in(inst, d, 1'b1);
      obs = get_obs(inst);
      n = 0;
      while (obs[1] !== 1'b1 && n < 50) begin
         @(negedge clk);
         obs = get_obs(inst);
         n++;
      end
      if (obs[1] === 1'b1) hs_ok = 1'b1;
      @(negedge clk);
      set_in(inst, d, 1'b0);
      for (int k = 0; k < ncyc; k++) begin
         cap[k] = get_obs(inst);
         @(negedge clk);
      end
   endtask

   task automatic test_reset;
      logic [3:0] obs;
      repeat (3) @(negedge clk);
      for (int i = 0; i < 3; i++) begin
         obs = get_obs(i);
         vectors++;
         if (obs !== 4'b1000) begin
            miscompares++;
            $display("FAIL reset_hold inst=%0d got=%b want=1000 (tx,busy,rdy,done)", i, obs);
         end
      end
      reset = 1'b0;
      @(negedge clk);
      for (int i = 0; i < 3; i++) begin
         obs = get_obs(i);
         vectors++;
         if (obs !== 4'b1010) begin
            miscompares++;
            $display("FAIL reset_release inst=%0d got=%b want=1010 (tx,busy,rdy,done)", i, obs);
         end
      end
   endtask

   task automatic test_8n1;
      logic [15:0] fr;
      logic [3:0] exp;
      fr = 16'b000000_1101001010;   // 0xA5: start, 1,0,1,0,0,1,0,1, stop
      capture(0, 9'h0A5, 102);
      vectors++;
      if (hs_ok !== 1'b1) begin miscompares++; $display("FAIL 8n1_handshake got=%b want=1", hs_ok); end
      for (int k = 0; k < 102; k++) begin
         if (k < 100) exp = {fr[k/10], 3'b100};
         else if (k == 100) exp = 4'b1011;
         else exp = 4'b1010;
         vectors++;
         if (cap[k] !== exp) begin
            miscompares++;
            $display("FAIL 8n1_a5 cyc=%0d got=%b want=%b", k, cap[k], exp);
         end
      end
   endtask

   task automatic test_7e2;
      logic [15:0] fr;
      logic [3:0] exp;
      fr = 16'b00000_11010100110;   // 0x53: start, 1,1,0,0,1,0,1, parity 0, stop, stop
      capture(1, 9'h053, 112);
      vectors++;
      if (hs_ok !== 1'b1) begin miscompares++; $display("FAIL 7e2_handshake got=%b want=1", hs_ok); end
      for (int k = 0; k < 112; k++) begin
         if (k < 110) exp = {fr[k/10], 3'b100};
         else if (k == 110) exp = 4'b1011;
         else exp = 4'b1010;
         vectors++;
         if (cap[k] !== exp) begin
            miscompares++;
            $display("FAIL 7e2_53 cyc=%0d got=%b want=%b", k, cap[k], exp);
         end
      end
   endtask

   task automatic test_8o1;
      logic [15:0] fr;
      logic [3:0] exp;
      fr = 16'b00000_11111111110;   // 0xFF: start, eight 1s, odd parity 1, stop
      capture(2, 9'h0FF, 112);
      vectors++;
      if (hs_ok !== 1'b1) begin miscompares++; $display("FAIL 8o1_handshake got=%b want=1", hs_ok); end
      for (int k = 0; k < 112; k++) begin
         if (k < 110) exp = {fr[k/10], 3'b100};
         else if (k == 110) exp = 4'b1011;
         else exp = 4'b1010;
         vectors++;
         if (cap[k] !== exp) begin
            miscompares++;
            $display("FAIL 8o1_ff cyc=%0d got=%b want=%b", k, cap[k], exp);
         end
      end
   endtask

   // s_valid held across two frames; s_data changes right after the first accept edge.
   // The accept of frame B happens in the single IDLE cycle that also carries done.
   task automatic test_back_to_back;
      logic [15:0] fa;
      logic [15:0] fb;
      logic [3:0] exp;
      int n;
      int fall;
      fa = 16'b000000_1000000000;   // 0x00
      fb = 16'b000000_1111111110;   // 0xFF
      @(negedge clk);
      d0 = 8'h00; v0 = 1'b1;
      n = 0;
      while (r0 !== 1'b1 && n < 50) begin @(negedge clk); n++; end
      vectors++;
      if (r0 !== 1'b1) begin miscompares++; $display("FAIL b2b_handshake got=%b want=1", r0); end
      @(negedge clk);
      d0 = 8'hFF;
      for (int k = 0; k < 202; k++) begin
         if (k == 101) v0 = 1'b0;
         cap[k] = get_obs(0);
         @(negedge clk);
      end
      for (int k = 0; k < 202; k++) begin
         if (k < 100) exp = {fa[k/10], 3'b100};
         else if (k == 100) exp = 4'b1011;
         else if (k < 201) exp = {fb[(k-101)/10], 3'b100};
         else exp = 4'b1011;
         vectors++;
         if (cap[k] !== exp) begin
            miscompares++;
            $display("FAIL b2b cyc=%0d got=%b want=%b", k, cap[k], exp);
         end
      end
      fall = -1;
      for (int k = 1; k < 202; k++)
         if (fall < 0 && cap[k-1][3] === 1'b1 && cap[k][3] === 1'b0) fall = k;
      vectors++;
      if (fall != 101) begin
         miscompares++;
         $display("FAIL b2b_start_spacing got=%0d want=101", fall);
      end
   endtask

   task automatic test_reset_mid_frame;
      logic [3:0] obs;
      logic [15:0] fr;
      logic [3:0] exp;
      int n;
      @(negedge clk);
      d0 = 8'hA5; v0 = 1'b1;
      n = 0;
      while (r0 !== 1'b1 && n < 50) begin @(negedge clk); n++; end
      vectors++;
      if (r0 !== 1'b1) begin miscompares++; $display("FAIL rst_mid_handshake got=%b want=1", r0); end
      @(negedge clk);                 // cycle 0
      v0 = 1'b0;
      repeat (34) @(negedge clk);     // cycle 34
      reset = 1'b1;                   // taken at edge E0+35
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         obs = get_obs(0);
         vectors++;
         if (obs !== 4'b1000) begin
            miscompares++;
            $display("FAIL rst_mid_hold step=%0d got=%b want=1000", k, obs);
         end
      end
      reset = 1'b0;
      for (int k = 0; k < 2; k++) begin
         @(negedge clk);
         obs = get_obs(0);
         vectors++;
         if (obs !== 4'b1010) begin
            miscompares++;
            $display("FAIL rst_mid_after step=%0d got=%b want=1010", k, obs);
         end
      end
      fr = 16'b000000_1001111000;     // 0x3C: start, 0,0,1,1,1,1,0,0, stop
      capture(0, 9'h03C, 102);
      vectors++;
      if (hs_ok !== 1'b1) begin miscompares++; $display("FAIL rst_3c_handshake got=%b want=1", hs_ok); end
      for (int k = 0; k < 102; k++) begin
         if (k < 100) exp = {fr[k/10], 3'b100};
         else if (k == 100) exp = 4'b1011;
         else exp = 4'b1010;
         vectors++;
         if (cap[k] !== exp) begin
            miscompares++;
            $display("FAIL rst_3c cyc=%0d got=%b want=%b", k, cap[k], exp);
         end
      end
   endtask

`ifdef UART_TX_BREAK_EN
   // Break and payload requested together: break first (130 low + 10 stop), then 0x55.
   task automatic test_break;
      logic [15:0] fr;
      logic [3:0] exp;
      fr = 16'b000000_1010101010;     // 0x55
      @(negedge clk);
      vectors++;
      if (r0 !== 1'b1) begin miscompares++; $display("FAIL brk_idle_precheck got=%b want=1", r0); end
      sb0 = 1'b1; v0 = 1'b1; d0 = 8'h55;
      @(negedge clk);                 // cycle 0
      sb0 = 1'b0;
      for (int k = 0; k < 242; k++) begin
         if (k == 141) v0 = 1'b0;
         cap[k] = get_obs(0);
         @(negedge clk);
      end
      for (int k = 0; k < 242; k++) begin
         if (k < 130) exp = 4'b0100;
         else if (k < 140) exp = 4'b1100;
         else if (k == 140) exp = 4'b1010;
         else if (k < 241) exp = {fr[(k-141)/10], 3'b100};
         else exp = 4'b1011;
         vectors++;
         if (cap[k] !== exp) begin
            miscompares++;
            $display("FAIL brk cyc=%0d got=%b want=%b", k, cap[k], exp);
         end
      end
   endtask
`endif

   initial begin
      vectors     = 0;
      miscompares = 0;
      reset = 1'b1;
      d0 = '0; v0 = 1'b0;
      d1 = '0; v1 = 1'b0;
      d2 = '0; v2 = 1'b0;
`ifdef UART_TX_BREAK_EN
      sb0 = 1'b0;
      sb_off = 1'b0;
`endif
      test_reset;
      test_8n1;
      test_7e2;
      test_8o1;
      test_back_to_back;
      test_reset_mid_frame;
`ifdef UART_TX_BREAK_EN
      test_break;
`endif
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
